// File: rtl/multi_fade_pwm.sv
// Multi-channel LED fade engine: a shared step prescaler and PWM counter drive
// per-channel fade FSMs, each started at a fixed phase offset for a chasing effect.

module fade_chan #(
  parameter int STEPS      = 166,
  parameter int HOLD_STEPS = 332,
  parameter int STEP_VAL   = 7,
  parameter int W          = 11,
  parameter int SW         = 9,
  parameter int INIT_POS   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         tick,
  input  logic         wrap,
  input  logic [W-1:0] pwm_cnt,
  output logic [W-1:0] value,
  output logic         pwm_out,
  output logic         cyc_end
);
  localparam logic [1:0] RISE = 2'd0, HOLD_HI = 2'd1, FALL = 2'd2, HOLD_LO = 2'd3;
  localparam int MAX = STEP_VAL * STEPS;
  localparam int P   = INIT_POS;

  // Reset image is derived from the channel's phase position at elaboration.
  localparam logic [1:0] INIT_ST =
    (P < STEPS)                ? RISE    :
    (P < STEPS + HOLD_STEPS)   ? HOLD_HI :
    (P < 2*STEPS + HOLD_STEPS) ? FALL    : HOLD_LO;
  localparam int INIT_STEP_I =
    (P < STEPS)                ? P                  :
    (P < STEPS + HOLD_STEPS)   ? P - STEPS          :
    (P < 2*STEPS + HOLD_STEPS) ? P - STEPS - HOLD_STEPS :
                                 P - 2*STEPS - HOLD_STEPS;
  localparam int INIT_VAL_I =
    (INIT_ST == RISE)    ? INIT_STEP_I * STEP_VAL :
    (INIT_ST == HOLD_HI) ? MAX :
    (INIT_ST == FALL)    ? MAX - INIT_STEP_I * STEP_VAL : 0;

  localparam logic [SW-1:0] INIT_STEP = SW'(INIT_STEP_I);
  localparam logic [W-1:0]  INIT_VAL  = W'(INIT_VAL_I);
  localparam logic [SW-1:0] LAST_RF   = SW'(STEPS - 1);
  localparam logic [SW-1:0] LAST_H    = SW'(HOLD_STEPS - 1);
  localparam logic [W-1:0]  INC       = W'(STEP_VAL);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [W-1:0]  val_q, val_d, shadow_q;
  logic          pwm_q, out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT_ST;
      step_q   <= INIT_STEP;
      val_q    <= INIT_VAL;
      shadow_q <= INIT_VAL;
      pwm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      val_q   <= val_d;
      if (wrap) shadow_q <= val_q;
      pwm_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    val_d   = val_q;
    if (tick) begin
      case (state_q)
        RISE: begin
          val_d = val_q + INC;
          if (step_q == LAST_RF) begin state_d = HOLD_HI; step_d = '0; end
          else step_d = step_q + SW'(1);
        end
        HOLD_HI: begin
          if (step_q == LAST_H) begin state_d = FALL; step_d = '0; end
          else step_d = step_q + SW'(1);
        end
        FALL: begin
          val_d = val_q - INC;
          if (step_q == LAST_RF) begin state_d = HOLD_LO; step_d = '0; end
          else step_d = step_q + SW'(1);
        end
        HOLD_LO: begin
          if (step_q == LAST_H) begin state_d = RISE; step_d = '0; end
          else step_d = step_q + SW'(1);
        end
        default: begin
          state_d = HOLD_LO;
          step_d  = '0;
          val_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    out_d   = en && (pwm_cnt < shadow_q);
    cyc_end = tick && (state_q == HOLD_LO) && (step_q == LAST_H);
    value   = val_q;
    pwm_out = pwm_q;
  end
endmodule

module multi_fade_pwm #(
  parameter int CHANNELS      = 3,
  parameter int STEP_INTERVAL = 12000,
  parameter int STEPS         = 166,
  parameter int HOLD_STEPS    = 332,
  parameter int PWM_INTERVAL  = 1200,
  parameter int STEP_VAL      = PWM_INTERVAL / STEPS,
  parameter int PHASE_STEPS   = (2*STEPS + 2*HOLD_STEPS) / CHANNELS,
  localparam int W            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [CHANNELS*W-1:0] pwm_value,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  cycle_done
);
  localparam int PSW  = $clog2(STEP_INTERVAL + 1);
  localparam int SMAX = (STEPS > HOLD_STEPS) ? STEPS : HOLD_STEPS;
  localparam int SW   = $clog2(SMAX + 1);

  logic [PSW-1:0]      presc;
  logic [W-1:0]        pwm_cnt;
  logic                tick, wrap;
  logic [CHANNELS-1:0] ch_end;

  assign tick = en && (presc == PSW'(STEP_INTERVAL - 1));
  assign wrap = en && (pwm_cnt == W'(PWM_INTERVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      cycle_done <= 1'b0;
    end else begin
      if (en) begin
        presc   <= tick ? '0 : presc + PSW'(1);
        pwm_cnt <= wrap ? '0 : pwm_cnt + W'(1);
      end
      cycle_done <= ch_end[0];
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    fade_chan #(
      .STEPS(STEPS), .HOLD_STEPS(HOLD_STEPS), .STEP_VAL(STEP_VAL),
      .W(W), .SW(SW), .INIT_POS(k * PHASE_STEPS)
    ) u_ch (
      .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .wrap(wrap),
      .pwm_cnt(pwm_cnt),
      .value(pwm_value[k*W +: W]),
      .pwm_out(pwm_out[k]),
      .cyc_end(ch_end[k])
    );
  end
endmodule

// File: tb/tb_multi_fade_pwm.sv
// Bench for multi_fade_pwm: positional fade model checked every cycle, plus
// hand-computed expectations for sequence, duty, freeze and async reset.

module tb_multi_fade_pwm;
  localparam int CH = 3, SI = 4, ST = 4, HS = 2, PI = 16;
  localparam int SV = PI / ST, MX = SV * ST, CYC = 2*ST + 2*HS, PH = CYC / CH;
  localparam int W = $clog2(PI + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [CH*W-1:0] pwm_value;
  logic [CH-1:0]   pwm_out;
  logic            cycle_done;

  multi_fade_pwm #(
    .CHANNELS(CH), .STEP_INTERVAL(SI), .STEPS(ST), .HOLD_STEPS(HS), .PWM_INTERVAL(PI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pwm_value(pwm_value), .pwm_out(pwm_out), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: e_cnt = enabled clock edges since reset; ticks = e_cnt / SI.
  int e_cnt;
  int m_shadow [CH];
  int m_out    [CH];
  int m_done;

  function automatic int fval(int k, int t);
    int p;
    p = (k * PH + t) % CYC;
    if (p < ST)           return p * SV;
    if (p < ST + HS)      return MX;
    if (p < 2*ST + HS)    return MX - (p - ST - HS) * SV;
    return 0;
  endfunction

  function automatic int ch_val(int k);
    return int'(pwm_value[k*W +: W]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_cnt = 0;
    for (int k = 0; k < CH; k++) begin
      m_shadow[k] = fval(k, 0);
      m_out[k]    = 0;
    end
    m_done = 0;
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (en) begin
      for (int k = 0; k < CH; k++) begin
        m_out[k] = ((e_cnt % PI) < m_shadow[k]) ? 1 : 0;
        if (e_cnt % PI == PI - 1) m_shadow[k] = fval(k, e_cnt / SI);
      end
      m_done = ((e_cnt % SI == SI - 1) && (((e_cnt / SI) + 1) % CYC == 0)) ? 1 : 0;
      e_cnt++;
    end else begin
      for (int k = 0; k < CH; k++) m_out[k] = 0;
      m_done = 0;
    end
    @(negedge clk);
    for (int k = 0; k < CH; k++) begin
      check($sformatf("model_value[%0d]", k), ch_val(k), fval(k, e_cnt / SI));
      check($sformatf("model_out[%0d]", k), int'(pwm_out[k]), m_out[k]);
    end
    check("model_done", int'(cycle_done), m_done);
  endtask

  int seq [13] = '{4, 8, 12, 16, 16, 16, 12, 8, 4, 0, 0, 0, 4};
  int h0p1, h0p2, h1p1, h2p1, h2p2, dcnt;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    repeat (3) cyc();
    check("rst_ch0", ch_val(0), 0);
    check("rst_ch1", ch_val(1), 16);
    check("rst_ch2", ch_val(2), 8);
    check("rst_out", int'(pwm_out), 0);
    check("rst_done", int'(cycle_done), 0);

    rst_n = 1'b1;
    en    = 1'b1;
    h0p1 = 0; h0p2 = 0; h1p1 = 0; h2p1 = 0; h2p2 = 0; dcnt = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (i <= 16) begin
        h0p1 += int'(pwm_out[0]);
        h1p1 += int'(pwm_out[1]);
        h2p1 += int'(pwm_out[2]);
      end else if (i <= 32) begin
        h0p2 += int'(pwm_out[0]);
        h2p2 += int'(pwm_out[2]);
      end
      dcnt += int'(cycle_done);
      if (i % 4 == 0 && i <= 52) check($sformatf("seq_ch0_tick%0d", i / 4), ch_val(0), seq[i/4 - 1]);
      if (i == 47) check("done_pre", int'(cycle_done), 0);
      if (i == 48) check("done_first", int'(cycle_done), 1);
      if (i == 49) check("done_width", int'(cycle_done), 0);
      if (i == 96) check("done_second", int'(cycle_done), 1);
    end
    check("duty_ch2_val8", h2p1, 8);
    check("duty_ch1_val16", h1p1, 16);
    check("duty_ch2_val0", h2p2, 0);
    check("glitch_ch0_p1", h0p1, 0);
    check("glitch_ch0_p2", h0p2, 12);
    check("done_count", dcnt, 2);

    // Freeze mid-rise with the prescaler at 1.
    cyc();
    check("frz_pre", ch_val(0), 4);
    en = 1'b0;
    repeat (37) cyc();
    check("frz_out", int'(pwm_out), 0);
    check("frz_val", ch_val(0), 4);
    en = 1'b1;
    cyc(); cyc();
    check("resume_no_tick", ch_val(0), 4);
    cyc();
    check("resume_tick", ch_val(0), 8);

    // Async reset while ch0 is at 12.
    rst_n = 1'b0;
    model_reset();
    cyc();
    rst_n = 1'b1;
    repeat (13) cyc();
    check("ar_pre", ch_val(0), 12);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ch0", ch_val(0), 0);
    check("ar_ch1", ch_val(1), 16);
    check("ar_ch2", ch_val(2), 8);
    check("ar_out", int'(pwm_out), 0);
    check("ar_done", int'(cycle_done), 0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    check("ar_restart", ch_val(0), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_fade_pwm.md
Name: multi_fade_pwm

Overview:
- Multi-channel LED fade engine. Each channel runs its own fade FSM (rise, hold high, fall, hold low) and drives its own glitch-free PWM output.
- Channels share one step prescaler and one PWM counter. Each channel starts at a fixed phase offset, giving a "chasing" fade across RGB or multi-LED arrays.
- Sits between the top-level clock/reset and the LED pins. Replaces single-channel fade plus external PWM comparator.

Parameters:
- CHANNELS, 3, number of independent fade/PWM channels (>=1).
- STEP_INTERVAL, 12000, clk cycles per fade step (1 ms at 12 MHz).
- STEPS, 166, steps in each rise and each fall segment (>=1).
- HOLD_STEPS, 332, steps spent in each hold segment (>=1).
- PWM_INTERVAL, 1200, clk cycles per PWM period (100 us).
- STEP_VAL, PWM_INTERVAL/STEPS, duty increment per step. Constraint: STEP_VAL*STEPS <= PWM_INTERVAL.
- PHASE_STEPS, (2*STEPS+2*HOLD_STEPS)/CHANNELS, cycle offset in steps between adjacent channels.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable. Low freezes all counters and FSMs and blanks the outputs.
- pwm_value  output  CHANNELS*W  per-channel current duty, with W=$clog2(PWM_INTERVAL+1); channel k in bits [k*W +: W].
- pwm_out  output  CHANNELS  per-channel PWM waveform, registered.
- cycle_done  output  1  one-cycle pulse when channel 0 completes a full fade cycle.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler=0, pwm_cnt=0, pwm_out=0, cycle_done=0. Each channel loads its phase position p=k*PHASE_STEPS.
- Mapping from position p to reset state, step_cnt and pwm_value, with MAX=STEP_VAL*STEPS:
  - p<STEPS: RISE, step p, value p*STEP_VAL.
  - p<STEPS+HOLD_STEPS: HOLD_HI, step p-STEPS, value MAX.
  - p<2*STEPS+HOLD_STEPS: FALL, step q=p-STEPS-HOLD_STEPS, value MAX-q*STEP_VAL.
  - otherwise: HOLD_LO, step p-2*STEPS-HOLD_STEPS, value 0.
  - Reset values are elaboration-time constants. Shadow duty registers load the same values.
- Prescaler: counts 0..STEP_INTERVAL-1 while en is high, then wraps. Internal tick is asserted in the cycle where prescaler==STEP_INTERVAL-1 and en is high. All logic is clocked by clk only; there are no derived clocks.
- On each tick, per channel:
  - RISE: value+=STEP_VAL. If step==STEPS-1, go to HOLD_HI with step=0; else step+=1.
  - HOLD_HI: value held. If step==HOLD_STEPS-1, go to FALL with step=0.
  - FALL: value-=STEP_VAL. If step==STEPS-1, go to HOLD_LO with step=0.
  - HOLD_LO: value held. If step==HOLD_STEPS-1, go to RISE with step=0.
  - In every state, if the end condition is not met, step+=1.
  - Full cycle = 2*STEPS+2*HOLD_STEPS ticks.
  - Value never under/overflows: it ends each rise at exactly MAX and each fall at exactly 0.
- Invalid state encodings: recover to HOLD_LO, step 0, value 0 on the next tick.
- PWM:
  - pwm_cnt counts 0..PWM_INTERVAL-1 while en is high.
  - Each channel's shadow duty loads pwm_value only on the cycle where pwm_cnt==PWM_INTERVAL-1, so duty changes only at PWM period boundaries.
  - pwm_out[k] is registered as (pwm_cnt < shadow[k]), giving 1 cycle latency from pwm_cnt.
  - Duty 0 gives constant low; duty PWM_INTERVAL gives constant high.
- cycle_done: high for exactly one clk cycle, registered, following the tick on which channel 0 moves HOLD_LO->RISE.
- en low: prescaler, pwm_cnt, FSMs and values hold. pwm_out is forced to 0 on the next edge. No tick and no cycle_done pulse occur.
- en high: counting resumes from the held counts with no lost or duplicated steps.
- Reset asserted mid-cycle: everything returns to the reset image immediately. Operation restarts from the phase positions on the first edge after release.
- Simultaneous tick and PWM wrap in the same cycle: the shadow register captures the pre-tick pwm_value. The new value is picked up at the next PWM wrap.

Test Plan (bench parameters: CHANNELS=3, STEP_INTERVAL=4, STEPS=4, HOLD_STEPS=2, PWM_INTERVAL=16, so STEP_VAL=4, MAX=16, PHASE_STEPS=4, cycle=12 ticks):
- Reset image: hold rst_n low -> pwm_value ch0=0 (RISE), ch1=16 (HOLD_HI), ch2=8 (FALL step 2); pwm_out=000; cycle_done=0.
- Fade sequence: release reset, en=1 -> ch0 reads 4,8,12,16,16,16,12,8,4,0,0,0,4 on successive ticks, one tick every 4 clk. cycle_done pulses once, 1 cycle after the 12th tick, and every 48 clk thereafter.
- PWM duty: with ch2 at value 8 -> pwm_out[2] high for exactly 8 of 16 cycles per period. Value 0 gives no highs; value 16 gives all highs.
- Glitch-free update: a tick lands mid-PWM-period -> pwm_out duty for that period is unchanged; the new duty appears from the next period start.
- en freeze: drop en for 37 cycles mid-rise -> pwm_out=0 from the next edge and pwm_value is constant. After en returns, the next tick occurs after exactly the remaining prescaler count.
- Async reset mid-operation: assert rst_n between clk edges while ch0=12 -> outputs return to the reset image before the next edge; the sequence restarts from 0.
